// File: rtl/decim_sample_buffer.sv
// decim_sample_buffer: rounds, shifts and saturates decimator samples, then queues them in a small FIFO
// with sticky saturation/overflow flags.
module decim_sample_buffer #(
    parameter int IN_W  = 17,
    parameter int OUT_W = 12,
    parameter int SHIFT = 5,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [IN_W-1:0]        in_data,
    input  logic                          out_ready,
    input  logic                          clr_flags,
    output logic                          out_valid,
    output logic signed [OUT_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]        fifo_count,
    output logic                          sat_flag,
    output logic                          ovf_flag
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic signed [IN_W:0] HALF = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] MAXV = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] MINV = (IN_W+1)'(-(2 ** (OUT_W - 1)));

    logic signed [IN_W:0]  sum, rnd;
    logic signed [OUT_W-1:0] sat_val, s1_data;
    logic                  hi, lo, s1_sat, w;
    logic [OUT_W-1:0]      mem [DEPTH];
    logic [AW-1:0]         wp, rp;
    logic [CW-1:0]         count;
    logic                  pop, full, wr, drop;

    // One extra bit of headroom keeps the rounding offset from wrapping at the top of the input range.
    always_comb begin
        sum     = {in_data[IN_W-1], in_data} + HALF;
        rnd     = sum >>> SHIFT;
        hi      = rnd > MAXV;
        lo      = rnd < MINV;
        sat_val = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : rnd[OUT_W-1:0];
    end

    assign out_valid  = count != '0;
    assign fifo_count = count;
    assign out_data   = out_valid ? mem[rp] : '0;
    assign pop        = out_valid & out_ready;
    assign full       = count == CW'(DEPTH);
    assign wr         = w & (~full | pop);
    assign drop       = w & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_data  <= '0;
            s1_sat   <= 1'b0;
            w        <= 1'b0;
            wp       <= '0;
            rp       <= '0;
            count    <= '0;
            sat_flag <= 1'b0;
            ovf_flag <= 1'b0;
        end else begin
            w <= in_valid;
            if (in_valid) begin
                s1_data <= sat_val;
                s1_sat  <= hi | lo;
            end
            if (wr)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            count    <= count + CW'(wr) - CW'(pop);
            sat_flag <= (w & s1_sat) | (sat_flag & ~clr_flags);
            ovf_flag <= drop | (ovf_flag & ~clr_flags);
        end
    end

    // Storage needs no reset: w is cleared asynchronously, so nothing is written during or right after rst.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wp] <= s1_data;
    end
endmodule

// File: tb/tb_decim_sample_buffer.sv
// tb_decim_sample_buffer: directed and random stimulus checked against a queue-based reference model.
module tb_decim_sample_buffer;
    localparam int IN_W  = 17;
    localparam int OUT_W = 12;
    localparam int SHIFT = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0, clr_flags = 1'b0;
    logic signed [IN_W-1:0]  in_data = '0;
    logic                    out_valid, sat_flag, ovf_flag;
    logic signed [OUT_W-1:0] out_data;
    logic [$clog2(DEPTH):0]  fifo_count;

    int total = 0, bad = 0;
    int q[$];
    bit pend = 0, pend_sat = 0, m_sat = 0, m_ovf = 0;
    int pend_val = 0;

    decim_sample_buffer #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
        .clr_flags(clr_flags), .out_valid(out_valid), .out_data(out_data), .fifo_count(fifo_count),
        .sat_flag(sat_flag), .ovf_flag(ovf_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int quant(input int x, output bit s);
        int d, v, r, hi, lo;
        d  = 2 ** SHIFT;
        v  = x + d / 2;
        r  = (v - (((v % d) + d) % d)) / d;
        hi = 2 ** (OUT_W - 1) - 1;
        lo = -(2 ** (OUT_W - 1));
        s  = (r > hi) || (r < lo);
        return r > hi ? hi : r < lo ? lo : r;
    endfunction

    task automatic model_reset();
        q.delete();
        pend  = 0;
        m_sat = 0;
        m_ovf = 0;
    endtask

    task automatic step(input bit iv, input int x, input bit rdy, input bit clr);
        bit pop;
        in_valid  = iv;
        in_data   = IN_W'(x);
        out_ready = rdy;
        clr_flags = clr;
        pop = (q.size() != 0) && rdy;
        if (clr) begin
            m_sat = 0;
            m_ovf = 0;
        end
        if (pop)
            void'(q.pop_front());
        if (pend) begin
            if (pend_sat)
                m_sat = 1;
            if (q.size() < DEPTH)
                q.push_back(pend_val);
            else
                m_ovf = 1;
        end
        pend = iv;
        if (iv)
            pend_val = quant(x, pend_sat);
        @(posedge clk);
        #1;
        check("valid", out_valid, q.size() != 0);
        check("count", fifo_count, q.size());
        if (q.size() != 0)
            check("data", out_data, q[0]);
        check("sat", sat_flag, m_sat);
        check("ovf", ovf_flag, m_ovf);
    endtask

    initial begin
        int rin[4]  = '{100, -100, 16, 15};
        int rout[4] = '{3, -3, 1, 0};
        int fexp[4] = '{2, 3, 4, 10};
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_data", out_data, 0);
        check("rst_sat", sat_flag, 0);
        check("rst_ovf", ovf_flag, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            step(1, rin[i], 1, 0);
            check("lat1_valid", out_valid, 0);
            step(0, 0, 1, 0);
            check("round", out_data, rout[i]);
            check("round_sat", sat_flag, 0);
            step(0, 0, 1, 0);
        end

        step(1, 65535, 1, 0);
        step(0, 0, 1, 0);
        check("sat_pos", out_data, 2047);
        check("sat_pos_flag", sat_flag, 1);
        step(1, -65536, 1, 0);
        step(0, 0, 1, 0);
        check("sat_neg", out_data, -2048);
        check("sat_neg_flag", sat_flag, 1);
        step(0, 0, 1, 1);
        check("sat_clr", sat_flag, 0);

        step(1, 64, 1, 0);
        check("lat_c1", out_valid, 0);
        step(0, 0, 1, 0);
        check("lat_c2", out_valid, 1);
        check("lat_data", out_data, 2);
        step(1, 32, 1, 0);
        step(1, 64, 1, 0);
        step(1, 96, 1, 0);
        repeat (4) step(0, 0, 1, 0);

        for (int i = 1; i <= 5; i++)
            step(1, 32 * i, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", ovf_flag, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_drain", out_data, i);
            step(0, 0, 1, 0);
        end
        check("ovf_empty", fifo_count, 0);
        step(0, 0, 0, 1);

        for (int i = 1; i <= 4; i++)
            step(1, 32 * i, 0, 0);
        repeat (2) step(0, 0, 0, 0);
        step(1, 320, 0, 0);
        step(0, 0, 1, 0);
        check("fullpop_count", fifo_count, 4);
        check("fullpop_ovf", ovf_flag, 0);
        for (int i = 0; i < 4; i++) begin
            check("fullpop_order", out_data, fexp[i]);
            step(0, 0, 1, 0);
        end

        step(1, 32, 0, 0);
        step(1, 64, 0, 0);
        step(1, 96, 0, 0);
        step(0, 0, 0, 0);
        step(1, 128, 0, 0);
        #3;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_count", fifo_count, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) step(0, 0, 1, 0);
        step(1, 64, 1, 0);
        step(0, 0, 1, 0);
        check("postrst_data", out_data, 2);
        step(0, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            int x;
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 131071)) - 65536
                                            : int'($urandom_range(0, 8191)) - 4096;
            step($urandom_range(0, 99) < 60, x, $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
